// File: rtl/axi_burst_mem_slave.sv
// axi_burst_mem_slave
//   Word-addressed AXI-style burst memory slave with independent read and
//   write engines sharing one byte-writable memory array.
//
// Parameters
//   DATA_W  data bus width (multiple of 8)
//   ADDR_W  word-address width
//   DEPTH   implemented words (DEPTH <= 2**ADDR_W); higher addresses are holes
//   ID_W    transaction ID width
//   LEN_W   burst length field width, beats = len + 1
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   ar*  (arvalid/arready/araddr/arlen/arid/arburst)  read address channel
//   r*   (rvalid/rready/rdata/rid/rresp/rlast)        read data channel
//   aw*  (awvalid/awready/awaddr/awlen/awid/awburst)  write address channel
//   w*   (wvalid/wready/wdata/wstrb/wlast)            write data channel
//   b*   (bvalid/bready/bid/bresp)                    write response channel
//   *burst: 0 = INCR, 1 = WRAP (WRAP legal only for power-of-two beat counts)
module axi_burst_mem_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 768,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  // AR
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [LEN_W-1:0]    arlen,
  input  logic [ID_W-1:0]     arid,
  input  logic                arburst,
  // R
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [ID_W-1:0]     rid,
  output logic [1:0]          rresp,
  output logic                rlast,
  // AW
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [LEN_W-1:0]    awlen,
  input  logic [ID_W-1:0]     awid,
  input  logic                awburst,
  // W
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  // B
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp
);

  localparam int              STRB_W  = DATA_W / 8;
  localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]      RESP_OK = 2'b00;
  localparam logic [1:0]      RESP_SE = 2'b10;

  // WRAP needs len+1 to be a power of two (len = 0 is a legal single beat).
  function automatic logic f_wrap_ok(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] n;
    n = {1'b0, len} + (LEN_W+1)'(1);
    return ((n & {1'b0, len}) == '0);
  endfunction

  // For a legal WRAP, len is an all-ones low-bit mask of the wrap block, so
  // the upper bits stay at the aligned base and the low bits roll over.
  function automatic logic [ADDR_W-1:0] f_beat_addr(
    input logic [ADDR_W-1:0] start,
    input logic [LEN_W-1:0]  len,
    input logic              wrap,
    input logic [LEN_W-1:0]  idx
  );
    logic [ADDR_W-1:0] lin;
    logic [ADDR_W-1:0] mask;
    lin  = start + ADDR_W'(idx);
    mask = ADDR_W'(len);
    if (wrap) return (start & ~mask) | (lin & mask);
    return lin;
  endfunction

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  // Memory has no reset: contents survive rst.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------- read
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  rstate_t             r_rstate, w_rstate_nxt;
  logic [ADDR_W-1:0]   r_raddr;
  logic [LEN_W-1:0]    r_rlen;
  logic [LEN_W-1:0]    r_rbeat;
  logic [ID_W-1:0]     r_rid;
  logic                r_rwrap;
  logic                r_rwrap_bad;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;

  logic                w_ar_hs, w_r_hs, w_rlast, w_rload;
  logic [ADDR_W-1:0]   w_rsel_start;
  logic [LEN_W-1:0]    w_rsel_len, w_rsel_idx;
  logic                w_rsel_wrap, w_rsel_bad;
  logic [ADDR_W-1:0]   w_raddr_nxt;
  logic                w_rok_nxt;

  always_comb begin
    w_rstate_nxt = r_rstate;
    arready      = 1'b0;
    rvalid       = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && w_rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_ar_hs = arvalid && arready;
  assign w_r_hs  = rvalid && rready;
  assign w_rlast = (r_rstate == R_DATA) && (r_rbeat == r_rlen);
  assign rlast   = w_rlast;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rid     = r_rid;

  // The data register is loaded one beat ahead: from the AR fields at the
  // address handshake, and from the captured fields after each non-final R
  // handshake. Reading before the write lands gives pre-write data when both
  // ports hit the same word in one cycle.
  always_comb begin
    if (w_ar_hs) begin
      w_rsel_start = araddr;
      w_rsel_len   = arlen;
      w_rsel_wrap  = arburst;
      w_rsel_idx   = '0;
      w_rsel_bad   = arburst && !f_wrap_ok(arlen);
    end else begin
      w_rsel_start = r_raddr;
      w_rsel_len   = r_rlen;
      w_rsel_wrap  = r_rwrap;
      w_rsel_idx   = r_rbeat + LEN_W'(1);
      w_rsel_bad   = r_rwrap_bad;
    end
    w_raddr_nxt = f_beat_addr(w_rsel_start, w_rsel_len, w_rsel_wrap, w_rsel_idx);
    w_rok_nxt   = !w_rsel_bad && f_in_range(w_raddr_nxt);
  end

  assign w_rload = w_ar_hs || (w_r_hs && !w_rlast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate    <= R_IDLE;
      r_raddr     <= '0;
      r_rlen      <= '0;
      r_rbeat     <= '0;
      r_rid       <= '0;
      r_rwrap     <= 1'b0;
      r_rwrap_bad <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_raddr     <= araddr;
        r_rlen      <= arlen;
        r_rid       <= arid;
        r_rwrap     <= arburst;
        r_rwrap_bad <= w_rsel_bad;
      end
      if (w_rload) begin
        r_rbeat <= w_rsel_idx;
        r_rdata <= w_rok_nxt ? r_mem[MEM_AW'(w_raddr_nxt)] : '0;
        r_rresp <= w_rok_nxt ? RESP_OK : RESP_SE;
      end
    end
  end

  // --------------------------------------------------------------- write
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  wstate_t             r_wstate, w_wstate_nxt;
  logic [ADDR_W-1:0]   r_waddr;
  logic [LEN_W-1:0]    r_wlen;
  logic [LEN_W-1:0]    r_wbeat;
  logic [ID_W-1:0]     r_wid;
  logic                r_wwrap;
  logic                r_wwrap_bad;
  logic                r_werr;
  logic [1:0]          r_bresp;

  logic                w_aw_hs, w_w_hs, w_wend, w_win, w_wen, w_beat_err;
  logic [ADDR_W-1:0]   w_waddr;

  always_comb begin
    w_wstate_nxt = r_wstate;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_wend) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  // Burst ends on whichever comes first: wlast or the final counted beat.
  assign w_wend  = wlast || (r_wbeat == r_wlen);
  assign w_waddr = f_beat_addr(r_waddr, r_wlen, r_wwrap, r_wbeat);
  assign w_win   = f_in_range(w_waddr);
  // wlast must coincide exactly with beat len; either mismatch is an error.
  assign w_beat_err = !w_win || r_wwrap_bad || (wlast != (r_wbeat == r_wlen));
  assign w_wen   = w_w_hs && w_win && !r_wwrap_bad;
  assign bid     = r_wid;
  assign bresp   = r_bresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate    <= W_IDLE;
      r_waddr     <= '0;
      r_wlen      <= '0;
      r_wbeat     <= '0;
      r_wid       <= '0;
      r_wwrap     <= 1'b0;
      r_wwrap_bad <= 1'b0;
      r_werr      <= 1'b0;
      r_bresp     <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_waddr     <= awaddr;
        r_wlen      <= awlen;
        r_wid       <= awid;
        r_wwrap     <= awburst;
        r_wwrap_bad <= awburst && !f_wrap_ok(awlen);
        r_wbeat     <= '0;
        r_werr      <= 1'b0;
      end
      if (w_w_hs) begin
        r_wbeat <= r_wbeat + LEN_W'(1);
        r_werr  <= r_werr || w_beat_err;
        if (w_wend) r_bresp <= (r_werr || w_beat_err) ? RESP_SE : RESP_OK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) r_mem[MEM_AW'(w_waddr)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule
